// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: 640x480@60 raster defaults, sync polarity and pin-pipeline record
package vga_timing_gen_pkg;
  localparam int TOTAL_COLS    = 800;
  localparam int TOTAL_ROWS    = 525;
  localparam int ACTIVE_COLS   = 640;
  localparam int ACTIVE_ROWS   = 480;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_WIDTH  = 96;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_WIDTH  = 2;
  localparam int VIDEO_DELAY   = 2;
  localparam logic SYNC_ACTIVE = 1'b0;
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] col;
  } pix_t;
  localparam pix_t PIX_IDLE = '{hs: !SYNC_ACTIVE, vs: !SYNC_ACTIVE, act: 1'b0, col: 10'd0};
  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: D-stage shift register of W-bit words with a per-instance reset value
module sync_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [D*W-1:0] sr;
  // Shift in at the bottom; the oldest word leaves at the top
  always_ff @(posedge clk)
    sr <= rst ? {D{RST}} : (D*W)'({sr, d});
  assign q = sr[D*W-1 -: W];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, game syncs, delayed pin syncs and blanked RGB (VGA_TEST_PATTERN_EN adds colour bars)
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int c_TOTAL_COLS    = TOTAL_COLS,
  parameter int c_TOTAL_ROWS    = TOTAL_ROWS,
  parameter int c_ACTIVE_COLS   = ACTIVE_COLS,
  parameter int c_ACTIVE_ROWS   = ACTIVE_ROWS,
  parameter int c_H_FRONT_PORCH = H_FRONT_PORCH,
  parameter int c_H_SYNC_WIDTH  = H_SYNC_WIDTH,
  parameter int c_V_FRONT_PORCH = V_FRONT_PORCH,
  parameter int c_V_SYNC_WIDTH  = V_SYNC_WIDTH,
  parameter int c_VIDEO_DELAY   = VIDEO_DELAY
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Test_Mode,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [3:0] o_VGA_Red,
  output logic [3:0] o_VGA_Grn,
  output logic [3:0] o_VGA_Blu
);
  localparam logic [9:0] LAST_COL = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] HS_LO    = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [9:0] HS_HI    = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam logic [9:0] VS_LO    = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [9:0] VS_HI    = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);
  logic       run;
  logic [9:0] col_n, row_n;
  logic [3:0] red, grn, blu;
  pix_t       pix, pix_d;
  // Next raster position; the first clock out of reset holds 0,0 so that pixel gets presented
  always_comb begin
    col_n = !run || o_Col_Count == LAST_COL ? 10'd0 : o_Col_Count + 10'd1;
    row_n = !run ? 10'd0 : o_Col_Count != LAST_COL ? o_Row_Count :
            o_Row_Count == LAST_ROW ? 10'd0 : o_Row_Count + 10'd1;
  end
  // Game-side registers: counts and their decodes always describe the same pixel
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      run           <= 1'b0;
      o_Col_Count   <= 10'd0;
      o_Row_Count   <= 10'd0;
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      run           <= 1'b1;
      o_Col_Count   <= col_n;
      o_Row_Count   <= row_n;
      o_HSync       <= col_n < ACT_COLS;
      o_VSync       <= row_n < ACT_ROWS;
      o_Frame_Start <= col_n == 10'd0 && row_n == 10'd0;
    end
  // Pin decode of the current pixel; active comes from the game syncs so a reset cycle enters as blank
  always_comb begin
    pix.hs  = in_win(o_Col_Count, HS_LO, HS_HI) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    pix.vs  = in_win(o_Row_Count, VS_LO, VS_HI) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    pix.act = o_HSync & o_VSync;
    pix.col = o_Col_Count;
  end
  sync_delay #(.W($bits(pix_t)), .D(c_VIDEO_DELAY), .RST(PIX_IDLE)) u_delay (
    .clk(i_Clk),
    .rst(i_Rst),
    .d  (pix),
    .q  (pix_d)
  );
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(c_ACTIVE_COLS / 8);
  logic [2:0] bar;
  // Colour bars: the three bar-index bits drive R, G, B at full scale
  always_comb begin
    bar = 3'(pix_d.col / BAR_W);
    red = i_Test_Mode ? {4{bar[2]}} : i_Red_Video;
    grn = i_Test_Mode ? {4{bar[1]}} : i_Grn_Video;
    blu = i_Test_Mode ? {4{bar[0]}} : i_Blu_Video;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{i_Test_Mode, pix_d.col};
  assign red = i_Red_Video;
  assign grn = i_Grn_Video;
  assign blu = i_Blu_Video;
`endif
  // Pin registers: syncs from the delayed decode, colour blanked outside the delayed active area
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      o_VGA_HSync <= !SYNC_ACTIVE;
      o_VGA_VSync <= !SYNC_ACTIVE;
      o_VGA_Red   <= 4'd0;
      o_VGA_Grn   <= 4'd0;
      o_VGA_Blu   <= 4'd0;
    end else begin
      o_VGA_HSync <= pix_d.hs;
      o_VGA_VSync <= pix_d.vs;
      o_VGA_Red   <= pix_d.act ? red : 4'd0;
      o_VGA_Grn   <= pix_d.act ? grn : 4'd0;
      o_VGA_Blu   <= pix_d.act ? blu : 4'd0;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a full-size and a shrunken raster against an arithmetic model of the pixel stream
module tb_vga_timing_gen;
  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs, vs, fs, vhs, vvs;
    logic [3:0] r, g, b;
  } obs_t;
  typedef struct {
    int         n;
    logic [9:0] col, row;
    logic       hs, vhs;
  } vec_t;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, tm = 1'b0, p_tm = 1'b0;
  logic [3:0] r = 4'd0, g = 4'd0, b = 4'd0, p_r = 4'd0, p_g = 4'd0, p_b = 4'd0;
  int n = 0, n_chk = 0, n_fail = 0;
  vec_t tab [10];
  logic hs_a, vs_a, fs_a, vhs_a, vvs_a, hs_b, vs_b, fs_b, vhs_b, vvs_b;
  logic [9:0] col_a, row_a, col_b, row_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  obs_t oa, ob;
  assign oa = {col_a, row_a, hs_a, vs_a, fs_a, vhs_a, vvs_a, r_a, g_a, b_a};
  assign ob = {col_b, row_b, hs_b, vs_b, fs_b, vhs_b, vvs_b, r_b, g_b, b_b};

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Test_Mode(tm),
    .i_Red_Video(r), .i_Grn_Video(g), .i_Blu_Video(b),
    .o_HSync(hs_a), .o_VSync(vs_a), .o_Col_Count(col_a), .o_Row_Count(row_a),
    .o_Frame_Start(fs_a), .o_VGA_HSync(vhs_a), .o_VGA_VSync(vvs_a),
    .o_VGA_Red(r_a), .o_VGA_Grn(g_a), .o_VGA_Blu(b_a)
  );

  vga_timing_gen #(
    .c_TOTAL_COLS(40), .c_TOTAL_ROWS(12), .c_ACTIVE_COLS(32), .c_ACTIVE_ROWS(8),
    .c_H_FRONT_PORCH(2), .c_H_SYNC_WIDTH(4), .c_V_FRONT_PORCH(1), .c_V_SYNC_WIDTH(2),
    .c_VIDEO_DELAY(3)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Test_Mode(tm),
    .i_Red_Video(r), .i_Grn_Video(g), .i_Blu_Video(b),
    .o_HSync(hs_b), .o_VSync(vs_b), .o_Col_Count(col_b), .o_Row_Count(row_b),
    .o_Frame_Start(fs_b), .o_VGA_HSync(vhs_b), .o_VGA_VSync(vvs_b),
    .o_VGA_Red(r_b), .o_VGA_Grn(g_b), .o_VGA_Blu(b_b)
  );

  // Expected outputs k cycles after reset release; colour inputs are those sampled one clock earlier
  function automatic obs_t model(input int tc, tr, ac, ar, hfp, hsw, vfp, vsw, d, k,
                                 input logic t, input logic [3:0] vr, vg, vb);
    obs_t e;
    int p, q, qc, qr, bar;
    p = k % (tc * tr);
    e.col = 10'(p % tc);
    e.row = 10'(p / tc);
    e.hs = p % tc < ac;
    e.vs = p / tc < ar;
    e.fs = p == 0;
    e.vhs = 1'b1;
    e.vvs = 1'b1;
    {e.r, e.g, e.b} = 12'h000;
    if (k > d) begin
      q = (k - d - 1) % (tc * tr);
      qc = q % tc;
      qr = q / tc;
      e.vhs = !(qc >= ac + hfp && qc < ac + hfp + hsw);
      e.vvs = !(qr >= ar + vfp && qr < ar + vfp + vsw);
      if (qc < ac && qr < ar) begin
        bar = qc / (ac / 8);
        {e.r, e.g, e.b} = (t && PAT) ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : {vr, vg, vb};
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %h expected %h", nm, n, got, exp);
    end
  endtask

  // One pixel clock: compare both rasters and landmarks, then drive the next inputs
  task automatic cyc(input bit rnd);
    chk("raster_a", 64'(oa), 64'(model(800, 525, 640, 480, 16, 96, 10, 2, 2, n, p_tm, p_r, p_g, p_b)));
    chk("raster_b", 64'(ob), 64'(model(40, 12, 32, 8, 2, 4, 1, 2, 3, n, p_tm, p_r, p_g, p_b)));
    foreach (tab[i])
      if (tab[i].n == n)
        chk($sformatf("landmark_%0d", tab[i].n), 64'({col_a, row_a, hs_a, vhs_a}),
            64'({tab[i].col, tab[i].row, tab[i].hs, tab[i].vhs}));
    if (rnd) begin
      tm = 1'($urandom);
      r = 4'($urandom);
      g = 4'($urandom);
      b = 4'($urandom);
    end
    {p_tm, p_r, p_g, p_b} = {tm, r, g, b};
    n++;
    @(negedge clk);
  endtask

  task automatic wait_col(input int c);
    int k = 0;
    while (col_a != 10'(c) && k < 1000) begin
      cyc(1'b0);
      k++;
    end
    chk("wait_col", 64'(col_a), 64'(c));
  endtask

  initial begin
    int cnt_hs = 0, cnt_vhs = 0, cnt_vvs_b = 0, cnt_fs_b = 0, cnt_fs_a = 0;
    tab[0] = '{0,    10'd0,   10'd0, 1'b1, 1'b1};
    tab[1] = '{639,  10'd639, 10'd0, 1'b1, 1'b1};
    tab[2] = '{640,  10'd640, 10'd0, 1'b0, 1'b1};
    tab[3] = '{658,  10'd658, 10'd0, 1'b0, 1'b1};
    tab[4] = '{659,  10'd659, 10'd0, 1'b0, 1'b0};
    tab[5] = '{754,  10'd754, 10'd0, 1'b0, 1'b0};
    tab[6] = '{755,  10'd755, 10'd0, 1'b0, 1'b1};
    tab[7] = '{799,  10'd799, 10'd0, 1'b0, 1'b1};
    tab[8] = '{800,  10'd0,   10'd1, 1'b1, 1'b1};
    tab[9] = '{1459, 10'd659, 10'd1, 1'b0, 1'b0};
    tm = 1'b1; r = 4'hF; g = 4'hF; b = 4'hF;
    repeat (4) @(negedge clk);
    chk("reset_state_a", 64'(oa), 64'({20'd0, 5'b00011, 12'h000}));
    chk("reset_state_b", 64'(ob), 64'({20'd0, 5'b00011, 12'h000}));
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (n < 800) begin
        cnt_hs += int'(hs_a);
        cnt_vhs += int'(!vhs_a);
      end
      if (n < 480) cnt_vvs_b += int'(!vvs_b);
      cnt_fs_b += int'(fs_b);
      cyc(1'b1);
    end
    chk("hsync_active_width", 64'(cnt_hs), 64'd640);
    chk("pin_hsync_width", 64'(cnt_vhs), 64'd96);
    chk("pin_vsync_width_b", 64'(cnt_vvs_b), 64'd80);
    chk("frame_starts_b", 64'(cnt_fs_b), 64'd5);
    tm = 1'b0; r = 4'h0; g = 4'h0; b = 4'h0;
    wait_col(102);
    chk("marker_pre", 64'(r_a), 64'h0);
    r = 4'hF;
    cyc(1'b0);
    r = 4'h0;
    chk("marker_hit", 64'(r_a), 64'hF);
    cyc(1'b0);
    chk("marker_post", 64'(r_a), 64'h0);
    wait_col(300);
    r = 4'hF; g = 4'hF; b = 4'hF;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_pins", 64'({vhs_a, vvs_a, r_a, g_a, b_a}), 64'({2'b11, 12'h000}));
      chk("reset_counts", 64'({col_a, row_a, hs_a, fs_a}), 64'd0);
    end
    tm = 1'b1; r = 4'h5; g = 4'h5; b = 4'h5;
    {p_tm, p_r, p_g, p_b} = {tm, r, g, b};
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    chk("restart", 64'({col_a, row_a, hs_a, vs_a, fs_a}), 64'({20'd0, 3'b111}));
    for (int i = 0; i < 800; i++) begin
      cnt_fs_a += int'(fs_a);
      if (n == 43)  chk("bar0_black", 64'({r_a, g_a, b_a}), 64'(PAT ? 12'h000 : 12'h555));
      if (n == 123) chk("bar1_blue",  64'({r_a, g_a, b_a}), 64'(PAT ? 12'h00F : 12'h555));
      if (n == 603) chk("bar7_white", 64'({r_a, g_a, b_a}), 64'(PAT ? 12'hFFF : 12'h555));
      if (n == 703) chk("blank_zero", 64'({r_a, g_a, b_a}), 64'h000);
      cyc(1'b0);
    end
    chk("frame_start_once", 64'(cnt_fs_a), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
